piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
Parallel-in, serial-out converter. It is the transmit-side counterpart of the serial-in shift registers in the shifter library. It accepts N-bit words over a valid/ready handshake and emits them one bit per clock on a serial line, framed by valid/first/last strobes. A one-word holding buffer allows gapless back-to-back words at full line rate (one word per N cycles).

Parameters:
N, 8, data word width in bits; legal range N >= 2
MSB_FIRST, 1, 1 = bit N-1 is transmitted first; 0 = bit 0 is transmitted first

Ports:
clk  input  1  clock; all state updates on the rising edge
resetn  input  1  synchronous, active-low reset
in_data  input  N  parallel word to transmit
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  block can accept a word this cycle
out_bit  output  1  serial data bit
out_valid  output  1  out_bit carries a data bit this cycle
out_first  output  1  out_bit is the first bit of a word
out_last  output  1  out_bit is the last bit of a word
busy  output  1  a word is being shifted out or is held

Behaviour:
- Reset: resetn sampled low at a rising edge of clk clears all state.
  - Outputs after that edge: out_bit=0, out_valid=0, out_first=0, out_last=0, busy=0, in_ready=1.
  - A word being shifted or held at reset is discarded; no partial word resumes.
- Handshake:
  - Accept occurs at an edge where in_valid=1 and in_ready=1.
  - in_ready = !hold_full. It is a function of registered state only; there is no combinational path from in_valid.
  - in_data is ignored when in_valid=0.
- Internal state:
  - shift register sreg[N-1:0].
  - bit counter cnt, width $clog2(N), range 0..N-1.
  - active flag.
  - holding register hold[N-1:0] plus hold_full.
- States:
  - IDLE: active=0.
  - SHIFT: active=1, cnt counts bits already sent.
- Load rules, evaluated each edge where resetn=1. Let end = active && cnt==N-1.
  - IDLE with accept: sreg<=in_data, cnt<=0, active<=1 (bypass; hold untouched).
  - SHIFT with !end: sreg shifts by one toward the output end, cnt<=cnt+1. An accept in this case writes hold and sets hold_full.
  - end with hold_full: sreg<=hold, cnt<=0, hold_full<=0. An accept in the same cycle is impossible, since in_ready=0.
  - end with !hold_full and accept: sreg<=in_data, cnt<=0 (bypass).
  - end with !hold_full and no accept: active<=0 (return to IDLE).
- Output mapping (combinational from registers):
  - out_valid=active.
  - out_bit = active ? (MSB_FIRST ? sreg[N-1] : sreg[0]) : 0.
  - out_first = active && cnt==0.
  - out_last = active && cnt==N-1.
  - busy = active || hold_full.
- Latency: a word accepted at edge k drives its first bit in the cycle following edge k. Its last bit follows at edge k+N-1.
- Throughput: with in_valid held high and words available, out_valid stays 1 continuously, with no gap between the last bit of one word and the first bit of the next.
- Shift direction: MSB_FIRST=1 shifts left with 0 fill; MSB_FIRST=0 shifts right with 0 fill.

Decomposition:
- Shared package shifter_pkg: state encoding constants (ST_IDLE, ST_SHIFT) and a CNT_W(N) width helper. The same package is used by the serial-in shifters.
- No sub-module; counter, shifter and holding register are inline. A separate bit-counter module is not warranted.

Test Plan:
1. N=8, MSB_FIRST=1, single accept of 0xA5 from idle -> next 8 cycles out_bit=1,0,1,0,0,1,0,1; out_first only in cycle 1; out_last only in cycle 8; then out_valid=0, busy=0.
2. Back-to-back: 0xA5 accepted, then 0x3C presented with in_valid held -> 0x3C accepted into hold in cycle 2. Expect 16 consecutive out_valid=1 cycles with bits 10100101 00111100 and out_first at cycles 1 and 9. in_ready=0 from cycle 2 until the hold drains at cycle 9.
3. Backpressure: three words 0x01, 0x02, 0x03 offered continuously -> the third word is held off (in_ready=0) until the hold drains. All 24 bits are emitted in order; no word is dropped or duplicated.
4. MSB_FIRST=0, word 0x01 -> out_bit=1 then seven 0s; out_last on the eighth bit.
5. Reset mid-word: accept 0xFF, then assert resetn=0 at bit 3 with a word in hold -> the next cycle shows out_valid=0, busy=0, in_ready=1. A new word 0x0F afterwards emits cleanly starting with out_first.
6. Idle gap: accept 0x80, wait 5 idle cycles, accept 0x01 -> out_valid=0 exactly during the gap; both words are correct; in_ready=1 throughout.

Source files
------------

// File: rtl/shifter_pkg.sv
// -----------------------------------------------------------------------------
// shifter_pkg
// Shared definitions for the shifter library, used by both the serial-in
// shift registers and the parallel-in/serial-out serializer.
//   - shift_state_e : two-state shifter FSM encoding (ST_IDLE, ST_SHIFT)
//   - CNT_W(n)      : width of a bit counter covering 0..n-1
// -----------------------------------------------------------------------------
package shifter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } shift_state_e;

    // Width of a counter that must hold values 0..n-1; at least one bit.
    function automatic int CNT_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
// Parallel-in, serial-out converter. Accepts N-bit words over a valid/ready
// handshake and emits them one bit per clock, framed by valid/first/last.
// A one-word holding register lets the next word wait while the current word
// is shifting, giving gapless back-to-back words at one word per N cycles.
//
// Parameters:
//   N         : word width in bits (N >= 2)
//   MSB_FIRST : 1 = bit N-1 sent first (shift left), 0 = bit 0 first (shift right)
//
// Ports:
//   clk        in   clock, rising edge
//   resetn     in   synchronous active-low reset
//   in_data    in   [N-1:0] parallel word
//   in_valid   in   in_data valid this cycle
//   in_ready   out  word can be accepted this cycle (registered state only)
//   out_bit    out  serial data bit (0 when idle)
//   out_valid  out  out_bit carries data
//   out_first  out  first bit of a word
//   out_last   out  last bit of a word
//   busy       out  a word is shifting or held
// -----------------------------------------------------------------------------
module piso_serializer
    import shifter_pkg::*;
#(
    parameter int N         = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         out_bit,
    output logic         out_valid,
    output logic         out_first,
    output logic         out_last,
    output logic         busy
);

    localparam int CW = CNT_W(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    shift_state_e  state_r, state_s;
    logic [N-1:0]  sreg_r, sreg_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [N-1:0]  hold_r, hold_s;
    logic          hold_full_r, hold_full_s;

    logic          accept_s;
    logic          word_end_s;
    logic [N-1:0]  sreg_shifted_s;

    // Handshake and end-of-word decode; in_ready never depends on in_valid.
    assign accept_s       = in_valid && !hold_full_r;
    assign word_end_s     = (state_r == ST_SHIFT) && (cnt_r == CNT_LAST);
    assign sreg_shifted_s = (MSB_FIRST != 0) ? {sreg_r[N-2:0], 1'b0}
                                             : {1'b0, sreg_r[N-1:1]};

    // State register: synchronous reset discards any word in flight or held.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            sreg_r      <= '0;
            cnt_r       <= '0;
            hold_r      <= '0;
            hold_full_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            sreg_r      <= sreg_s;
            cnt_r       <= cnt_s;
            hold_r      <= hold_s;
            hold_full_r <= hold_full_s;
        end
    end

    // Next-state logic: load, shift, hold refill and return to idle.
    always_comb begin
        state_s     = state_r;
        sreg_s      = sreg_r;
        cnt_s       = cnt_r;
        hold_s      = hold_r;
        hold_full_s = hold_full_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    // Bypass the hold: first bit appears the very next cycle.
                    sreg_s  = in_data;
                    cnt_s   = '0;
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!word_end_s) begin
                    sreg_s = sreg_shifted_s;
                    cnt_s  = cnt_r + CW'(1);
                    if (accept_s) begin
                        hold_s      = in_data;
                        hold_full_s = 1'b1;
                    end else begin
                        hold_full_s = hold_full_r;
                    end
                end else if (hold_full_r) begin
                    // in_ready is low here, so no accept can collide.
                    sreg_s      = hold_r;
                    cnt_s       = '0;
                    hold_full_s = 1'b0;
                end else if (accept_s) begin
                    sreg_s = in_data;
                    cnt_s  = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode straight from registered state.
    assign in_ready  = !hold_full_r;
    assign out_valid = (state_r == ST_SHIFT);
    assign out_bit   = (state_r == ST_SHIFT)
                     ? ((MSB_FIRST != 0) ? sreg_r[N-1] : sreg_r[0])
                     : 1'b0;
    assign out_first = (state_r == ST_SHIFT) && (cnt_r == '0);
    assign out_last  = (state_r == ST_SHIFT) && (cnt_r == CNT_LAST);
    assign busy      = (state_r == ST_SHIFT) || hold_full_r;

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
// Drives one MSB-first and one LSB-first serializer (N=8) with the same
// directed stimulus. A word-queue model predicts every output each cycle;
// captured bit streams are also compared against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [N-1:0] in_data = '0;
    logic         in_valid = 1'b0;

    logic m_ready, m_bit, m_valid, m_first, m_last, m_busy;
    logic l_ready, l_bit, l_valid, l_first, l_last, l_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    piso_serializer #(.N(N), .MSB_FIRST(1)) u_msb (
        .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
        .in_ready(m_ready), .out_bit(m_bit), .out_valid(m_valid),
        .out_first(m_first), .out_last(m_last), .busy(m_busy)
    );

    piso_serializer #(.N(N), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
        .in_ready(l_ready), .out_bit(l_bit), .out_valid(l_valid),
        .out_first(l_first), .out_last(l_last), .busy(l_busy)
    );

    // ---------------- behavioural model ----------------
    // mq[0] is the word on the line, mq[1] (if present) is waiting.
    // midx is how many bits of mq[0] have already been sent.
    logic [N-1:0] mq[$];
    int           midx = 0;
    logic         chk_en = 1'b0;

    always @(posedge clk) begin
        bit rdy_now;
        if (!resetn) begin
            mq.delete();
            midx = 0;
        end else begin
            rdy_now = (mq.size() < 2);
            if (mq.size() > 0) begin
                if (midx == N - 1) begin
                    void'(mq.pop_front());
                    midx = 0;
                end else begin
                    midx++;
                end
            end
            if (in_valid && rdy_now) mq.push_back(in_data);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of both DUTs against the model.
    always @(negedge clk) begin
        logic e_valid, e_mbit, e_lbit, e_first, e_last, e_ready;
        logic [N-1:0] w;
        if (chk_en) begin
            e_valid = (mq.size() > 0);
            e_ready = (mq.size() < 2);
            w       = e_valid ? mq[0] : '0;
            e_mbit  = e_valid ? w[N-1-midx] : 1'b0;
            e_lbit  = e_valid ? w[midx] : 1'b0;
            e_first = e_valid && (midx == 0);
            e_last  = e_valid && (midx == N - 1);
            chk("msb_valid", 32'(m_valid), 32'(e_valid));
            chk("msb_bit",   32'(m_bit),   32'(e_mbit));
            chk("msb_first", 32'(m_first), 32'(e_first));
            chk("msb_last",  32'(m_last),  32'(e_last));
            chk("msb_busy",  32'(m_busy),  32'(e_valid));
            chk("msb_ready", 32'(m_ready), 32'(e_ready));
            chk("lsb_valid", 32'(l_valid), 32'(e_valid));
            chk("lsb_bit",   32'(l_bit),   32'(e_lbit));
            chk("lsb_first", 32'(l_first), 32'(e_first));
            chk("lsb_last",  32'(l_last),  32'(e_last));
            chk("lsb_busy",  32'(l_busy),  32'(e_valid));
            chk("lsb_ready", 32'(l_ready), 32'(e_ready));
        end
    end

    // ---------------- stream capture for literal checks ----------------
    logic [31:0] cap_m, cap_l;
    int          n_valid, n_first, n_last, run, max_run;

    always @(negedge clk) begin
        if (m_valid === 1'b1) begin
            cap_m = {cap_m[30:0], m_bit};
            n_valid++;
            run++;
            if (run > max_run) max_run = run;
            if (m_first === 1'b1) n_first++;
            if (m_last === 1'b1) n_last++;
        end else begin
            run = 0;
        end
        if (l_valid === 1'b1) cap_l = {cap_l[30:0], l_bit};
    end

    task automatic cap_clear();
        @(negedge clk);
        #1;
        cap_m = '0; cap_l = '0;
        n_valid = 0; n_first = 0; n_last = 0; run = 0; max_run = 0;
    endtask

    // Offer a word until the model says it was taken; in_valid stays high.
    task automatic send(input logic [N-1:0] w);
        bit done = 1'b0;
        bit rdy;
        for (int t = 0; t < 64 && !done; t++) begin
            @(negedge clk);
            #1;
            in_valid = 1'b1;
            in_data  = w;
            rdy = (mq.size() < 2);
            @(posedge clk);
            if (rdy) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word %0h never accepted", w);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            in_valid = 1'b0;
            in_data  = N'($urandom);
        end
    endtask

    initial begin
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        #1;
        chk("reset_ready", 32'(m_ready), 32'd1);
        chk("reset_valid", 32'(m_valid), 32'd0);
        chk("reset_busy",  32'(l_busy),  32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Test 1: single word 0xA5 from idle.
        cap_clear();
        send(8'hA5);
        idle(12);
        chk("t1_bits_msb", cap_m, 32'h0000_00A5);
        chk("t1_bits_lsb", cap_l, 32'h0000_00A5);
        chk("t1_first",    32'(n_first), 32'd1);
        chk("t1_last",     32'(n_last),  32'd1);
        chk("t1_busy_end", 32'(m_busy),  32'd0);

        // Test 2 and 4 (LSB side): back-to-back 0xA5 then 0x3C.
        cap_clear();
        send(8'hA5);
        send(8'h3C);
        idle(20);
        chk("t2_bits_msb", cap_m, 32'h0000_A53C);
        chk("t2_bits_lsb", cap_l, 32'h0000_A53C);
        chk("t2_run",      32'(max_run), 32'd16);
        chk("t2_first",    32'(n_first), 32'd2);

        // Test 3: three words offered continuously, third is held off.
        cap_clear();
        send(8'h01);
        send(8'h02);
        send(8'h03);
        idle(28);
        chk("t3_bits_msb", cap_m, 32'h0001_0203);
        chk("t3_bits_lsb", cap_l, 32'h0080_40C0);
        chk("t3_run",      32'(max_run), 32'd24);

        // Test 4: LSB-first 0x01 -> 1 then seven 0s.
        cap_clear();
        send(8'h01);
        idle(12);
        chk("t4_bits_lsb", cap_l, 32'h0000_0080);
        chk("t4_last",     32'(n_last), 32'd1);

        // Test 5: reset mid-word with a word held.
        send(8'hFF);
        send(8'h55);
        idle(1);
        @(negedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_valid", 32'(m_valid), 32'd0);
        chk("t5_busy",  32'(m_busy),  32'd0);
        chk("t5_ready", 32'(m_ready), 32'd1);
        chk("t5_lbusy", 32'(l_busy),  32'd0);
        cap_clear();
        resetn = 1'b1;
        send(8'h0F);
        idle(12);
        chk("t5_bits_msb", cap_m, 32'h0000_000F);
        chk("t5_bits_lsb", cap_l, 32'h0000_00F0);
        chk("t5_first",    32'(n_first), 32'd1);
        chk("t5_count",    32'(n_valid), 32'd8);

        // Test 6: idle gap between two words.
        cap_clear();
        send(8'h80);
        idle(13);
        send(8'h01);
        idle(12);
        chk("t6_bits_msb", cap_m, 32'h0000_8001);
        chk("t6_count",    32'(n_valid), 32'd16);
        chk("t6_run",      32'(max_run), 32'd8);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
